median_window_gen: RTL and testbench
====================================

# median_window_gen

Streaming 3x3 window generator that sits directly upstream of the `median_mat` median filter. It accepts one raster-order pixel per cycle, stores the two previous image lines in on-chip line buffers, and presents the nine neighbourhood pixels on ports `a`..`k` in the order `median_mat` consumes them. It also raises `out_valid` for every fully interior window.

## Interface
- `DATA_W`, default 16: pixel width; matches the `median_mat` operand width.
- `IMG_W`, default 640: pixels per line, minimum 3.
- `IMG_H`, default 480: lines per frame, minimum 3.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` carries a pixel this cycle.
- `in_sof`  in  1: qualifies with `in_valid`; this pixel is frame position (0,0).
- `in_data`  in  DATA_W: pixel value.
- `a`, `b`, `c`  out  DATA_W each: top window row, left to right.
- `d`, `e`, `f`  out  DATA_W each: middle window row; `e` is the centre pixel.
- `g`, `h`, `k`  out  DATA_W each: bottom window row.
- `out_valid`  out  1: `a`..`k` hold a complete interior window.
- `frame_done`  out  1: one-cycle pulse coinciding with the last window of a frame.
- `in_ready`, `out_ready`: present only with `MEDIAN_WIN_BACKPRESSURE_EN` (see Configuration).

## Operation
- **Accept condition:**
  - Without the macro, a pixel is accepted when `in_valid` = 1.
  - With the macro, a pixel is accepted when `in_valid` and `in_ready` are both 1.
- **Position counters:** `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1.
  - Each accept advances `col`; `col` wraps to 0 and increments `row`.
  - After (IMG_H-1, IMG_W-1), both counters wrap to (0,0).
- **Start of frame:** an accepted pixel with `in_sof` = 1 is treated as position (0,0), whatever the counter values were. The counters then continue from (0,1).
- **Line buffers:** two buffers, `lb1` (older line) and `lb0`, each IMG_W x DATA_W, indexed by `col`. On each accept:
  - the new window column is {`lb1[col]`, `lb0[col]`, `in_data`};
  - then `lb1[col]` <= `lb0[col]` and `lb0[col]` <= `in_data`.
- **Window registers:** the nine output registers shift left by one column on every accept. For an accepted pixel at (r,c), the window registered on the next cycle is:
  - `a`=P(r-2,c-2), `b`=P(r-2,c-1), `c`=P(r-2,c)
  - `d`=P(r-1,c-2), `e`=P(r-1,c-1), `f`=P(r-1,c)
  - `g`=P(r,c-2), `h`=P(r,c-1), `k`=P(r,c)
- **out_valid:** set on an accept with r>=2 and c>=2; cleared on an accept that does not meet that condition.
  - Without the macro, `out_valid` also clears on any cycle with no accept, so it is a one-cycle pulse per window.
  - With the macro, `out_valid` clears only when the window is consumed (`out_ready` = 1) and no new window is produced.
- **Border handling:** no padding. Border pixels produce no window, giving exactly (IMG_W-2)*(IMG_H-2) windows per frame.
- **frame_done:** asserted together with `out_valid` for the window from pixel (IMG_H-1, IMG_W-1).
- **Line buffer clearing:** not required. Every window position with r>=2 reads only lines written earlier in the same frame.

## Timing
- **Reset:** while `rst_n` = 0, `a`..`k` = 0, `out_valid` = 0, `frame_done` = 0, counters = (0,0), and `in_ready` = 1 (macro build). Line buffer contents are don't-care.
- **Latency:** one cycle. `out_valid` rises on the clock edge after the accept of pixel (r,c>=2, r>=2).
- **Throughput:** one pixel per cycle, one window per cycle sustained within interior runs.
- **Idle cycles:** gaps in `in_valid` freeze the counters, line buffers and window registers.
- **Reset mid-frame:** the first accept after release is position (0,0), with or without `in_sof`.
- **Simultaneous events:** `in_sof` together with a counter wrap resolves to (0,0); `in_sof` has priority.
- **Line buffer ports:** one read and one write of the same address per cycle. Read-before-write semantics are required.

## Configuration
- **Macro:** `MEDIAN_WIN_BACKPRESSURE_EN`.
- **When defined:**
  - adds input `out_ready` and output `in_ready`;
  - `in_ready` = `out_ready` || !`out_valid` (combinational);
  - while `out_valid` && !`out_ready`, the outputs `a`..`k`, `out_valid` and `frame_done` hold stable and no pixel is accepted.
- **When undefined:**
  - neither port exists;
  - every `in_valid` cycle is accepted;
  - the downstream stage must sample `a`..`k` in the cycle `out_valid` is high.

## Test plan
All scenarios use IMG_W=4 and IMG_H=4.

1. **Basic window:** reset, then stream P(r,c)=16r+c continuously with `in_sof` on the first pixel.
   - First `out_valid` appears one cycle after pixel 34 is accepted, with a..k = 0,1,2,16,17,18,32,33,34.
   - Exactly 4 windows are produced, centres `e` = 17,18,33,34.
   - `frame_done` is asserted with the window whose `k` = 51.
2. **Gapped input:** same stream with random `in_valid` gaps.
   - Window contents and count are identical to scenario 1.
   - `out_valid` never asserts in a no-accept cycle+1 (pulse-only build).
3. **Back-to-back frames:** two frames without gaps, the second with values +256.
   - The second frame's first window is 256,257,258,272,273,274,288,289,290.
   - No window mixes data from the two frames.
4. **Mid-frame in_sof:** assert `in_sof` at frame position (2,1), then stream a full frame.
   - No window appears before the restarted frame's (2,2).
   - Exactly 4 windows follow.
5. **Reset mid-frame:** assert `rst_n` low at position (3,1).
   - All outputs read 0 immediately (asynchronous reset).
   - The following full frame matches scenario 1.
6. **Backpressure (macro defined):** hold `out_ready` = 0 when the first window appears.
   - `in_ready` = 0 and a..k stay at 0..34 for 5 cycles.
   - After `out_ready` rises, the next window has `e` = 18, with no data lost.

Source files
------------

// File: rtl/median_window_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// median_window_gen : raster-order 3x3 window generator feeding median_mat.
// Optional handshake: define MEDIAN_WIN_BACKPRESSURE_EN.          Rev 1.0
// ----------------------------------------------------------------------------
module median_window_gen #(
   parameter int DATA_W = 16,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic [DATA_W-1:0] in_data,
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
   input  logic              out_ready,
   output logic              in_ready,
`endif
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] c,
   output logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] e,
   output logic [DATA_W-1:0] f,
   output logic [DATA_W-1:0] g,
   output logic [DATA_W-1:0] h,
   output logic [DATA_W-1:0] k,
   output logic              out_valid,
   output logic              frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];

   logic [COL_W-1:0] col, cur_col, nxt_col;
   logic [ROW_W-1:0] row, cur_row, nxt_row;
   logic             accept, col_last, row_last, win_ok, last_pix;

`ifdef MEDIAN_WIN_BACKPRESSURE_EN
   assign in_ready = out_ready || !out_valid;
   assign accept   = in_valid && in_ready;
`else
   assign accept   = in_valid;
`endif

   // in_sof overrides the running counters so a frame can restart anywhere
   always_comb begin
      cur_col  = in_sof ? '0 : col;
      cur_row  = in_sof ? '0 : row;
      col_last = (cur_col == COL_W'(IMG_W - 1));
      row_last = (cur_row == ROW_W'(IMG_H - 1));
      nxt_col  = col_last ? '0 : cur_col + COL_W'(1);
      nxt_row  = cur_row;
      if (col_last)
         nxt_row = row_last ? '0 : cur_row + ROW_W'(1);
      win_ok   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      last_pix = row_last && col_last;
   end

   // Line buffers carry no reset; reads see the pre-write contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[cur_col] <= lb0[cur_col];
         lb0[cur_col] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col        <= '0;
         row        <= '0;
         a          <= '0;
         b          <= '0;
         c          <= '0;
         d          <= '0;
         e          <= '0;
         f          <= '0;
         g          <= '0;
         h          <= '0;
         k          <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else if (accept) begin
         col        <= nxt_col;
         row        <= nxt_row;
         a          <= b;
         b          <= c;
         c          <= lb1[cur_col];
         d          <= e;
         e          <= f;
         f          <= lb0[cur_col];
         g          <= h;
         h          <= k;
         k          <= in_data;
         out_valid  <= win_ok;
         frame_done <= last_pix;
      end else begin
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
         if (out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
         end
`else
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_median_window_gen.sv
`default_nettype none
// tb_median_window_gen : directed 4x4-frame checks of the 3x3 window generator.
module tb_median_window_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_sof;
   logic [15:0] in_data;
   logic [15:0] a, b, c, d, e, f, g, h, k;
   logic        out_valid, frame_done;
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
   logic        out_ready, in_ready;
`endif

   int n_vec = 0;
   int n_err = 0;
   int win_cnt, fd_cnt;

   always #5 clk = ~clk;

   median_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sof     (in_sof),
      .in_data    (in_data),
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
      .out_ready  (out_ready),
      .in_ready   (in_ready),
`endif
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .e          (e),
      .f          (f),
      .g          (g),
      .h          (h),
      .k          (k),
      .out_valid  (out_valid),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      logic [15:0] w [9];
      w = '{a, b, c, d, e, f, g, h, k};
      for (int i = 0; i < 9; i++)
         check($sformatf("%s win[%0d]", tag, i), w[i], 0);
      check({tag, " out_valid"}, out_valid, 0);
      check({tag, " frame_done"}, frame_done, 0);
   endtask

   // Apply one pixel P(r,cc)=base+16r+cc and check the window it registers.
   task automatic pix(input int base, input int r, input int cc, input bit sof);
      logic [15:0] w [9];
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = 16'(base + 16 * r + cc);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      check($sformatf("out_valid r%0d c%0d", r, cc), out_valid, (r >= 2 && cc >= 2));
      check($sformatf("frame_done r%0d c%0d", r, cc), frame_done, (r == 3 && cc == 3));
      if (out_valid) win_cnt++;
      if (frame_done) fd_cnt++;
      if (r >= 2 && cc >= 2) begin
         w = '{a, b, c, d, e, f, g, h, k};
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               check($sformatf("win r%0d c%0d [%0d]", r, cc, 3 * i + j), w[3 * i + j],
                     base + 16 * (r - 2 + i) + (cc - 2 + j));
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle out_valid", out_valid, 0);
      check("idle frame_done", frame_done, 0);
   endtask

`ifdef MEDIAN_WIN_BACKPRESSURE_EN
   // Entered right after the (2,2) window appears; pixel (2,3) waits on the stall.
   task automatic do_stall(input int base);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'(base + 16 * 2 + 3);
      #1;
      check("stall in_ready", in_ready, 0);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("stall out_valid", out_valid, 1);
         check("stall a", a, base + 0);
         check("stall e", e, base + 17);
         check("stall k", k, base + 34);
         check("stall in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1;
      check("release in_ready", in_ready, 1);
      in_valid = 1'b0;
   endtask
`endif

   task automatic frame(input int base, input bit sof_first, input bit gaps, input bit stall);
      win_cnt = 0;
      fd_cnt  = 0;
      for (int r = 0; r < 4; r++)
         for (int cc = 0; cc < 4; cc++) begin
            if (gaps)
               repeat ($urandom_range(0, 2)) idle();
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
            if (stall && r == 2 && cc == 3) do_stall(base);
`endif
            pix(base, r, cc, sof_first && r == 0 && cc == 0);
         end
      check("window count", win_cnt, 4);
      check("frame_done count", fd_cnt, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
      out_ready = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
`ifdef MEDIAN_WIN_BACKPRESSURE_EN
      check("reset in_ready", in_ready, 1);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      frame(0, 1'b1, 1'b0, 1'b0);        // basic window
      frame(0, 1'b1, 1'b1, 1'b0);        // gapped input
      frame(0, 1'b1, 1'b0, 1'b0);        // back-to-back frames
      frame(256, 1'b1, 1'b0, 1'b0);

      // restart with in_sof at counter position (2,1)
      for (int i = 0; i < 9; i++) pix(0, i / 4, i % 4, i == 0);
      frame(512, 1'b1, 1'b0, 1'b0);

      // asynchronous reset while at position (3,1)
      for (int i = 0; i < 13; i++) pix(0, i / 4, i % 4, i == 0);
      rst_n = 1'b0;
      #1;
      check_zero("async reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      frame(0, 1'b0, 1'b0, 1'b0);

`ifdef MEDIAN_WIN_BACKPRESSURE_EN
      frame(0, 1'b1, 1'b0, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
